// File: rtl/led_display_ctrl.sv
// led_display_ctrl
// Snapshots one of four CPU-side values and shows it on an 8-digit
// multiplexed, active-low common-anode seven-segment display. Hex values are
// loaded in one step; decimal values go through a 32-step double-dabble
// engine. The display buffer only changes once a complete result is ready.
module led_display_ctrl #(
    parameter int unsigned SCAN_DIV    = 100000,  // cycles each digit is lit, >= 2
    parameter int unsigned REFRESH_DIV = 5000000  // cycles between periodic snapshots, >= 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] led_data_in,
    input  logic [31:0] total_cycles,
    input  logic [31:0] condi_branch_num,
    input  logic [31:0] uncondi_branch_num,
    input  logic [1:0]  disp_sel,
    input  logic        dec_mode,
    input  logic        freeze,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int REF_W  = $clog2(REFRESH_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);

    // Buffer digit code: 0..15 is a hex/BCD digit, BLANK switches all segments off.
    typedef logic [4:0] code_t;
    localparam code_t BLANK = 5'h10;

    // The chosen branch out of IDLE also records the latched display mode.
    typedef enum logic [1:0] {IDLE, HEXLD, SHIFT, DONE} state_t;

    // Scan state and registered display drive.
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]        dig_idx_q, dig_idx_d;
    logic [7:0]        an_q;
    logic [6:0]        seg_q;
    logic              dp_q;

    // Request generation.
    logic [REF_W-1:0]  refresh_cnt_q, refresh_cnt_d;
    logic [1:0]        sel_prev_q;
    logic              mode_prev_q;
    logic              pend_q, pend_d;
    logic              refresh_wrap;
    logic              new_req;
    logic              accept;
    logic [31:0]       src;

    // Conversion engine and display buffer.
    state_t            state_q, state_d;
    logic [31:0]       snap_q, snap_d;
    logic [39:0]       bcd_q, bcd_d;
    logic [39:0]       bcd_adj;
    logic [4:0]        iter_q, iter_d;
    logic              busy_q, busy_d;
    logic [7:0][4:0]   buf_code_q, buf_code_d;
    logic [7:0]        buf_dp_q, buf_dp_d;  // 1 = decimal point lit
    logic [9:0]        nz;                  // BCD digit j is nonzero

    function automatic logic [6:0] seg_of(input code_t c);
        case (c)
            5'h00: seg_of = 7'h40;
            5'h01: seg_of = 7'h79;
            5'h02: seg_of = 7'h24;
            5'h03: seg_of = 7'h30;
            5'h04: seg_of = 7'h19;
            5'h05: seg_of = 7'h12;
            5'h06: seg_of = 7'h02;
            5'h07: seg_of = 7'h78;
            5'h08: seg_of = 7'h00;
            5'h09: seg_of = 7'h10;
            5'h0A: seg_of = 7'h08;
            5'h0B: seg_of = 7'h03;
            5'h0C: seg_of = 7'h46;
            5'h0D: seg_of = 7'h21;
            5'h0E: seg_of = 7'h06;
            5'h0F: seg_of = 7'h0E;
            default: seg_of = 7'h7F;
        endcase
    endfunction

    // Digit scan timing: hold each digit SCAN_DIV cycles, then step 0..7 and wrap.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        dig_idx_d  = dig_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            dig_idx_d  = dig_idx_q + 3'd1;
        end
    end

    // Scan counters and the registered an/seg/dp drive, one cycle behind index/buffer.
    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignments so every read in this block sees pre-edge values.
        if (rst) begin
            scan_cnt_q <= '0;
            dig_idx_q  <= '0;
            an_q       <= 8'hFF;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            dig_idx_q  <= dig_idx_d;
            an_q       <= ~(8'b1 << dig_idx_q);
            seg_q      <= seg_of(buf_code_q[dig_idx_q]);
            dp_q       <= ~buf_dp_q[dig_idx_q];
        end
    end

    // Request sources, pending-flag collapse and source selection.
    always_comb begin
        refresh_wrap  = (refresh_cnt_q == REF_LAST);
        refresh_cnt_d = refresh_wrap ? '0 : refresh_cnt_q + REF_W'(1);
        new_req       = (refresh_wrap | (disp_sel != sel_prev_q) | (dec_mode != mode_prev_q))
                        & ~freeze;
        // A request arriving in the accepting cycle merges with the one being served.
        accept        = (state_q == IDLE) & (pend_q | new_req);
        pend_d        = ~accept & (pend_q | new_req);
        unique case (disp_sel)
            2'd0: src = led_data_in;
            2'd1: src = total_cycles;
            2'd2: src = condi_branch_num;
            2'd3: src = uncondi_branch_num;
        endcase
    end

    // Double-dabble adjust step and per-digit nonzero flags for blanking.
    always_comb begin
        bcd_adj = bcd_q;
        nz      = '0;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
            nz[i] = (bcd_q[4*i +: 4] != 4'd0);
        end
    end

    // Conversion FSM next-state: snapshot, hex load or 32 shift steps, then one buffer write.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        bcd_d      = bcd_q;
        iter_d     = iter_q;
        busy_d     = busy_q;
        buf_code_d = buf_code_q;
        buf_dp_d   = buf_dp_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    snap_d  = src;
                    bcd_d   = '0;
                    iter_d  = '0;
                    busy_d  = 1'b1;
                    state_d = dec_mode ? SHIFT : HEXLD;
                end
            end
            HEXLD: begin
                for (int i = 0; i < 8; i++) begin
                    buf_code_d[i] = {1'b0, snap_q[4*i +: 4]};
                end
                buf_dp_d = '0;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            SHIFT: begin
                bcd_d  = (bcd_adj << 1) | 40'(snap_q[31]);
                snap_d = snap_q << 1;
                iter_d = iter_q + 5'd1;
                if (iter_q == 5'd31) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A digit is shown if it or any more significant BCD digit is nonzero;
                // a value of 10^8 or more therefore shows all eight digits.
                for (int i = 0; i < 8; i++) begin
                    if (i == 0 || (nz >> i) != 10'd0) begin
                        buf_code_d[i] = {1'b0, bcd_q[4*i +: 4]};
                    end else begin
                        buf_code_d[i] = BLANK;
                    end
                end
                buf_dp_d = {(nz[8] | nz[9]), 7'b0};
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // Conversion FSM, display buffer and request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            snap_q        <= '0;
            bcd_q         <= '0;
            iter_q        <= '0;
            busy_q        <= 1'b0;
            pend_q        <= 1'b1;
            refresh_cnt_q <= '0;
            // NOTE: the buffer is only eight small registers and must read blank after reset, so it is reset like any flop.
            buf_code_q    <= {8{BLANK}};
            buf_dp_q      <= '0;
        end else begin
            state_q       <= state_d;
            snap_q        <= snap_d;
            bcd_q         <= bcd_d;
            iter_q        <= iter_d;
            busy_q        <= busy_d;
            pend_q        <= pend_d;
            refresh_cnt_q <= refresh_cnt_d;
            buf_code_q    <= buf_code_d;
            buf_dp_q      <= buf_dp_d;
        end
        // Previous-cycle copies for change detection track the inputs even during reset.
        sel_prev_q  <= disp_sel;
        mode_prev_q <= dec_mode;
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_led_display_ctrl.sv
// tb_led_display_ctrl
// Transaction-level model of the display controller: scan position from a
// cycle count, results computed with plain division, buffer swaps scheduled
// by a latency countdown. Every cycle the DUT outputs are compared to it,
// alongside directed checks with hand-computed literal expectations.
module tb_led_display_ctrl;

    localparam int SD = 4;
    localparam int RD = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] led_data_in = 32'h1234ABCD;
    logic [31:0] total_cycles = 32'd0;
    logic [31:0] condi_branch_num = 32'd0;
    logic [31:0] uncondi_branch_num = 32'd0;
    logic [1:0]  disp_sel = 2'd0;
    logic        dec_mode = 1'b0;
    logic        freeze = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;

    always #5 clk = ~clk;

    led_display_ctrl #(.SCAN_DIV(SD), .REFRESH_DIV(RD)) dut (
        .clk                (clk),
        .rst                (rst),
        .led_data_in        (led_data_in),
        .total_cycles       (total_cycles),
        .condi_branch_num   (condi_branch_num),
        .uncondi_branch_num (uncondi_branch_num),
        .disp_sel           (disp_sel),
        .dec_mode           (dec_mode),
        .freeze             (freeze),
        .an                 (an),
        .seg                (seg),
        .dp                 (dp),
        .busy               (busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return (d >= 0 && d < 16) ? tbl[d] : 7'h7F;
    endfunction

    // ---------------- behavioural model ----------------
    int          m_n;          // non-reset edges since the last reset
    bit          m_pend, m_busy, m_valid;
    int          m_cnt;        // edges left until the pending result lands in the buffer
    logic [6:0]  m_seg [8];    // segments currently held by the buffer
    bit          m_dp [8];     // 1 = dp lit
    logic [6:0]  r_seg [8];    // result waiting to be written
    bit          r_dp [8];
    logic [1:0]  m_psel;
    bit          m_pmode;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_busy;
    int          m_idx;
    bit          m_req;

    task automatic load_result(input logic [31:0] v, input bit dec);
        longint unsigned x;
        int dg [10];
        int top;
        if (!dec) begin
            for (int i = 0; i < 8; i++) begin
                r_seg[i] = seg_of(int'((v >> (4*i)) & 32'hF));
                r_dp[i]  = 1'b0;
            end
        end else begin
            x = longint'(v);
            top = 0;
            for (int i = 0; i < 10; i++) begin
                dg[i] = int'(x % 10);
                x = x / 10;
                if (dg[i] != 0) top = i;
            end
            for (int i = 0; i < 8; i++) begin
                r_seg[i] = (i > top) ? 7'h7F : seg_of(dg[i]);
                r_dp[i]  = 1'b0;
            end
            r_dp[7] = (v >= 32'd100000000);
        end
    endtask

    function automatic logic [31:0] src_val();
        case (disp_sel)
            2'd0: return led_data_in;
            2'd1: return total_cycles;
            2'd2: return condi_branch_num;
            default: return uncondi_branch_num;
        endcase
    endfunction

    initial begin
        m_valid = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_busy = 1'b0;
                m_n = 0; m_pend = 1'b1; m_busy = 1'b0; m_cnt = 0;
                for (int i = 0; i < 8; i++) begin
                    m_seg[i] = 7'h7F;
                    m_dp[i]  = 1'b0;
                end
                m_valid = 1'b1;
            end else begin
                m_idx = (m_n / SD) % 8;
                e_an  = ~(8'h01 << m_idx);
                e_seg = m_seg[m_idx];
                e_dp  = ~m_dp[m_idx];
                m_req = ((m_n % RD) == RD - 1 || disp_sel != m_psel || dec_mode != m_pmode) && !freeze;
                if (m_busy) begin
                    if (m_req) m_pend = 1'b1;
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_seg  = r_seg;
                        m_dp   = r_dp;
                        m_busy = 1'b0;
                    end
                end else if (m_pend || m_req) begin
                    load_result(src_val(), dec_mode);
                    m_cnt  = dec_mode ? 33 : 1;
                    m_busy = 1'b1;
                    m_pend = 1'b0;
                end
                e_busy = m_busy;
                m_n++;
            end
            m_psel  = disp_sel;
            m_pmode = dec_mode;
        end
    end

    // Per-cycle compare against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("an", {24'd0, an}, {24'd0, e_an});
                check("seg", {25'd0, seg}, {25'd0, e_seg});
                check("dp", {31'd0, dp}, {31'd0, e_dp});
                check("busy", {31'd0, busy}, {31'd0, e_busy});
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    task automatic settle();
        cycles(2);
        wait_idle();
        cycles(3);
    endtask

    task automatic expect_digit(input string name, input int i, input logic [6:0] s, input logic d);
        logic [7:0] a;
        int k = 0;
        a = ~(8'h01 << i);
        while (an !== a && k < 64) begin
            @(negedge clk);
            k++;
        end
        check({name, "_an"}, {24'd0, an}, {24'd0, a});
        check({name, "_seg"}, {25'd0, seg}, {25'd0, s});
        check({name, "_dp"}, {31'd0, dp}, {31'd0, d});
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 4))
            0: return 32'($urandom_range(0, 999));
            1: return 32'd99999999 + 32'($urandom_range(0, 2));
            2: return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        // 1. Reset values, then hex snapshot of led_data_in.
        cycles(2);
        check("rst_an", {24'd0, an}, 32'hFF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_dp", {31'd0, dp}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("first_snap_busy", {31'd0, busy}, 32'd1);
        settle();
        expect_digit("hex_d0", 0, 7'h21, 1'b1);
        expect_digit("hex_d1", 1, 7'h46, 1'b1);
        expect_digit("hex_d2", 2, 7'h03, 1'b1);
        expect_digit("hex_d3", 3, 7'h08, 1'b1);
        expect_digit("hex_d7", 7, 7'h79, 1'b1);

        // 2. Decimal 12345 from total_cycles; busy lasts 33 cycles.
        wait_idle();
        total_cycles = 32'd12345;
        disp_sel = 2'd1;
        dec_mode = 1'b1;
        @(negedge clk);
        k = 0;
        while (busy === 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("busy_len", 32'(k), 32'd33);
        cycles(3);
        expect_digit("dec_d0", 0, 7'h12, 1'b1);
        expect_digit("dec_d1", 1, 7'h19, 1'b1);
        expect_digit("dec_d2", 2, 7'h30, 1'b1);
        expect_digit("dec_d3", 3, 7'h24, 1'b1);
        expect_digit("dec_d4", 4, 7'h79, 1'b1);
        expect_digit("dec_d5", 5, 7'h7F, 1'b1);
        expect_digit("dec_d7", 7, 7'h7F, 1'b1);

        // 3. Overflow: 4294967295 shows 94967295 with dp lit on digit 7.
        wait_idle();
        led_data_in = 32'hFFFFFFFF;
        disp_sel = 2'd0;
        settle();
        expect_digit("ovf_d0", 0, 7'h12, 1'b1);
        expect_digit("ovf_d1", 1, 7'h10, 1'b1);
        expect_digit("ovf_d2", 2, 7'h24, 1'b1);
        expect_digit("ovf_d3", 3, 7'h78, 1'b1);
        expect_digit("ovf_d4", 4, 7'h02, 1'b1);
        expect_digit("ovf_d5", 5, 7'h10, 1'b1);
        expect_digit("ovf_d6", 6, 7'h19, 1'b1);
        expect_digit("ovf_d7", 7, 7'h10, 1'b0);

        // 4. Zero in decimal: a single '0'.
        wait_idle();
        uncondi_branch_num = 32'd0;
        disp_sel = 2'd3;
        settle();
        expect_digit("zero_d0", 0, 7'h40, 1'b1);
        expect_digit("zero_d1", 1, 7'h7F, 1'b1);
        expect_digit("zero_d7", 7, 7'h7F, 1'b1);

        // 5. Select change mid-conversion: 98765 first, then the pending 31.
        wait_idle();
        total_cycles = 32'd98765;
        condi_branch_num = 32'd31;
        disp_sel = 2'd1;
        @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        cycles(10);
        disp_sel = 2'd2;
        wait_idle();
        cycles(1);
        expect_digit("mid_first_d0", 0, 7'h12, 1'b1);
        check("mid_second_busy", {31'd0, busy}, 32'd1);
        wait_idle();
        cycles(3);
        expect_digit("mid_next_d0", 0, 7'h79, 1'b1);
        expect_digit("mid_next_d1", 1, 7'h30, 1'b1);
        expect_digit("mid_next_d2", 2, 7'h7F, 1'b1);

        // 6a. Freeze: nothing changes across three refresh periods.
        freeze = 1'b1;
        led_data_in = 32'h0BADF00D;
        total_cycles = 32'd777;
        condi_branch_num = 32'd4242;
        uncondi_branch_num = 32'd5;
        disp_sel = 2'd0;
        dec_mode = 1'b0;
        cycles(3 * RD);
        expect_digit("frz_d0", 0, 7'h79, 1'b1);
        expect_digit("frz_d1", 1, 7'h30, 1'b1);
        expect_digit("frz_d2", 2, 7'h7F, 1'b1);

        // 6b. Reset during SHIFT aborts and blanks.
        freeze = 1'b0;
        wait_idle();
        dec_mode = 1'b1;
        @(negedge clk);
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        cycles(5);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_an", {24'd0, an}, 32'hFF);
        check("abort_seg", {25'd0, seg}, 32'h7F);
        rst = 1'b0;
        @(negedge clk);
        check("abort_blank_an", {24'd0, an}, 32'hFE);
        check("abort_blank_seg", {25'd0, seg}, 32'h7F);

        // Randomized phase, checked every cycle by the model.
        for (int it = 0; it < 80; it++) begin
            led_data_in = rand_val();
            total_cycles = rand_val();
            condi_branch_num = rand_val();
            uncondi_branch_num = rand_val();
            if ($urandom_range(0, 2) == 0) disp_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) dec_mode = ~dec_mode;
            freeze = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                cycles($urandom_range(1, 2));
                rst = 1'b0;
            end
            cycles($urandom_range(1, 60));
        end
        freeze = 1'b0;
        cycles(80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
